// File: rtl/spi_reg_master.sv
// Burst SPI master (mode 0) for sensor register access, with sensor power-up sequencing.
// Outputs are registered except cmd_ready/wdata_ack/busy/powered. A command is taken only in IDLE.
module spi_reg_master #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 8,
    parameter int LEN_W          = 4,
    parameter int HALF_DIV       = 1,
    parameter int STARTUP_CYCLES = 50
) (
    input  logic              FSM_CLK,
    input  logic              RST,
    input  logic              power_on,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              powered,
    output logic              CLK_IN,
    output logic              SYS_RES_N,
    output logic              SPI_EN,
    output logic              SPI_CLK,
    output logic              SPI_IN,
    input  logic              SPI_OUT,
    output logic [3:0]        State
);

    localparam logic [3:0] S_OFF   = 4'd0;
    localparam logic [3:0] S_WARM  = 4'd1;
    localparam logic [3:0] S_RSTW  = 4'd2;
    localparam logic [3:0] S_IDLE  = 4'd3;
    localparam logic [3:0] S_LEAD  = 4'd4;
    localparam logic [3:0] S_HDR   = 4'd5;
    localparam logic [3:0] S_DATA  = 4'd6;
    localparam logic [3:0] S_TRAIL = 4'd7;
    localparam logic [3:0] S_GAP   = 4'd8;

    localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
    localparam int ST_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(HALF_DIV - 1);
    localparam logic [ST_W-1:0]  ST_LAST    = ST_W'(STARTUP_CYCLES - 1);

    logic [3:0]        r_state;
    logic [ST_W-1:0]   r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_bit;
    logic [LEN_W-1:0]  r_words;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdv;
    logic              r_gap;
    logic              r_clk_in;
    logic              r_sys_res_n;
    logic              r_spi_en;
    logic              r_spi_clk;
    logic              r_spi_in;

    logic w_tick;
    logic w_txn;

    assign w_tick = (r_div == '0);
    assign w_txn  = (r_state >= S_LEAD) && (r_state <= S_GAP);

    assign cmd_ready   = (r_state == S_IDLE) && power_on;
    assign busy        = w_txn;
    assign powered     = (r_state >= S_IDLE) && (r_state <= S_GAP);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdv;
    assign CLK_IN      = r_clk_in;
    assign SYS_RES_N   = r_sys_res_n;
    assign SPI_EN      = r_spi_en;
    assign SPI_CLK     = r_spi_clk;
    assign SPI_IN      = r_spi_in;
    assign State       = r_state;

    // Combinational so the host sees the ack in the very cycle wdata is sampled.
    assign wdata_ack = !RST && power_on && r_wr && w_tick && r_spi_clk && (r_bit == '0) &&
                       ((r_state == S_HDR) || ((r_state == S_DATA) && (r_words != '0)));

    always_ff @(posedge FSM_CLK) begin
        if (RST || ((r_state != S_OFF) && !power_on)) begin
            r_state     <= S_OFF;
            r_cnt       <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_words     <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_sh        <= '0;
            r_rdv       <= 1'b0;
            r_gap       <= 1'b0;
            r_clk_in    <= 1'b0;
            r_sys_res_n <= 1'b0;
            r_spi_en    <= 1'b0;
            r_spi_clk   <= 1'b0;
            r_spi_in    <= 1'b0;
            if (RST) r_rdata <= '0;
        end else begin
            r_rdv    <= 1'b0;
            r_clk_in <= (r_state == S_OFF) ? power_on : ~r_clk_in;
            if (w_txn) r_div <= w_tick ? DIV_RELOAD : r_div - DIV_W'(1);
            case (r_state)
                S_OFF: if (power_on) begin
                    r_cnt   <= '0;
                    r_state <= S_WARM;
                end
                S_WARM, S_RSTW: begin
                    if (r_cnt == ST_LAST) begin
                        r_cnt       <= '0;
                        r_sys_res_n <= 1'b1;
                        r_state     <= (r_state == S_WARM) ? S_RSTW : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + ST_W'(1);
                    end
                end
                S_IDLE: if (cmd_valid) begin
                    r_wr     <= cmd_wr;
                    r_addr   <= cmd_addr;
                    r_words  <= cmd_len;
                    r_bit    <= CNT_W'(ADDR_W);
                    r_div    <= DIV_RELOAD;
                    r_spi_en <= 1'b1;
                    r_spi_in <= cmd_wr;
                    r_state  <= S_LEAD;
                end
                S_LEAD: if (w_tick) begin
                    r_spi_clk <= 1'b1;
                    r_state   <= S_HDR;
                end
                S_HDR: if (w_tick) begin
                    r_spi_clk <= ~r_spi_clk;
                    if (r_spi_clk) begin
                        if (r_bit == '0) begin
                            r_bit    <= CNT_W'(DATA_W - 1);
                            r_state  <= S_DATA;
                            r_sh     <= r_wr ? wdata : r_sh;
                            r_spi_in <= r_wr & wdata[DATA_W-1];
                        end else begin
                            r_bit    <= r_bit - CNT_W'(1);
                            r_spi_in <= r_addr[ADDR_W-1];
                            r_addr   <= r_addr << 1;
                        end
                    end
                end
                S_DATA: if (w_tick) begin
                    r_spi_clk <= ~r_spi_clk;
                    if (!r_spi_clk) begin
                        if (!r_wr) begin
                            r_sh <= {r_sh[DATA_W-2:0], SPI_OUT};
                            if (r_bit == '0) begin
                                r_rdata <= {r_sh[DATA_W-2:0], SPI_OUT};
                                r_rdv   <= 1'b1;
                            end
                        end
                    end else if (r_bit == '0) begin
                        // r_words counts down to zero, so an all-ones length still yields 2^LEN_W words.
                        if (r_words == '0) begin
                            r_spi_in <= 1'b0;
                            r_state  <= S_TRAIL;
                        end else begin
                            r_words  <= r_words - LEN_W'(1);
                            r_bit    <= CNT_W'(DATA_W - 1);
                            r_sh     <= r_wr ? wdata : r_sh;
                            r_spi_in <= r_wr & wdata[DATA_W-1];
                        end
                    end else begin
                        r_bit <= r_bit - CNT_W'(1);
                        if (r_wr) begin
                            r_spi_in <= r_sh[DATA_W-2];
                            r_sh     <= r_sh << 1;
                        end
                    end
                end
                S_TRAIL: if (w_tick) begin
                    r_spi_en <= 1'b0;
                    r_gap    <= 1'b0;
                    r_state  <= S_GAP;
                end
                S_GAP: if (w_tick) begin
                    if (r_gap) r_state <= S_IDLE;
                    else       r_gap   <= 1'b1;
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: scoreboarded frame bits and read words, plus a HALF_DIV=3 instance.
module tb_spi_reg_master;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int HDR    = 1 + ADDR_W;

    logic FSM_CLK = 1'b0;
    always #5 FSM_CLK = ~FSM_CLK;

    logic              RST = 1'b1, power_on = 1'b0, cmd_valid = 1'b0, cmd_valid2 = 1'b0;
    logic              cmd_wr = 1'b0, SPI_OUT = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] wdata = '0;

    logic              cmd_ready, wdata_ack, rdata_valid, busy, powered;
    logic              CLK_IN, SYS_RES_N, SPI_EN, SPI_CLK, SPI_IN;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        State;

    logic              cmd_ready2, wdata_ack2, rdata_valid2, busy2, powered2;
    logic              CLK_IN2, SYS_RES_N2, SPI_EN2, SPI_CLK2, SPI_IN2;
    logic [DATA_W-1:0] rdata2;
    logic [3:0]        State2;

    spi_reg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .HALF_DIV(1), .STARTUP_CYCLES(50)) dut (
        .FSM_CLK(FSM_CLK), .RST(RST), .power_on(power_on), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .wdata_ack(wdata_ack),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .powered(powered), .CLK_IN(CLK_IN),
        .SYS_RES_N(SYS_RES_N), .SPI_EN(SPI_EN), .SPI_CLK(SPI_CLK), .SPI_IN(SPI_IN), .SPI_OUT(SPI_OUT),
        .State(State));

    spi_reg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .HALF_DIV(3), .STARTUP_CYCLES(50)) u_div (
        .FSM_CLK(FSM_CLK), .RST(RST), .power_on(power_on), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .wdata_ack(wdata_ack2),
        .rdata(rdata2), .rdata_valid(rdata_valid2), .busy(busy2), .powered(powered2), .CLK_IN(CLK_IN2),
        .SYS_RES_N(SYS_RES_N2), .SPI_EN(SPI_EN2), .SPI_CLK(SPI_CLK2), .SPI_IN(SPI_IN2), .SPI_OUT(1'b0),
        .State(State2));

    int errors = 0, checks = 0;
    int cyc = 0, edge_cnt = 0, last_edges = 0, ack_cnt = 0, rdv_cnt = 0, acc_cnt = 0;
    bit ack_pending = 0, chk_bits = 1, chk_rd = 1;
    logic prev_clk = 1'b0, prev_en = 1'b0;
    bit exp_bits[$];
    logic [DATA_W-1:0] exp_rdata[$];
    bit sensor_bits [0:255];
    logic [DATA_W-1:0] wwords [0:15];
    bit mon_eb;
    logic [DATA_W-1:0] mon_er;

    always @(posedge FSM_CLK) cyc++;

    // Monitor and sensor model, sampled mid-cycle.
    always @(negedge FSM_CLK) begin
        if (prev_en && !SPI_EN) last_edges = edge_cnt;
        if (!SPI_EN) edge_cnt = 0;
        else if (SPI_CLK && !prev_clk) begin
            edge_cnt++;
            if (chk_bits) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL frame_bit: unexpected edge %0d, SPI_IN=%b", edge_cnt, SPI_IN);
                end else begin
                    mon_eb = exp_bits.pop_front();
                    if (SPI_IN !== mon_eb) begin
                        errors++;
                        $display("FAIL frame_bit: edge %0d SPI_IN=%b expected %b", edge_cnt, SPI_IN, mon_eb);
                    end
                end
            end
        end
        prev_clk = SPI_CLK;
        prev_en  = SPI_EN;
        SPI_OUT  = (edge_cnt >= HDR && edge_cnt - HDR < 256) ? sensor_bits[edge_cnt - HDR] : 1'b0;
        if (wdata_ack) begin
            ack_cnt++;
            ack_pending = 1;
        end
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (rdata_valid) begin
            rdv_cnt++;
            if (chk_rd) begin
                checks++;
                if (exp_rdata.size() == 0) begin
                    errors++;
                    $display("FAIL rdata: unexpected pulse, rdata=%h", rdata);
                end else begin
                    mon_er = exp_rdata.pop_front();
                    if (rdata !== mon_er) begin
                        errors++;
                        $display("FAIL rdata: got %h expected %h", rdata, mon_er);
                    end
                end
            end
        end
    end

    // Host write-data source: advance to the next word after each ack.
    always @(posedge FSM_CLK) begin
        #1;
        if (ack_pending) begin
            ack_pending = 0;
            wdata = wwords[ack_cnt % 16];
        end
    end

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    task automatic set_sensor_byte(input int idx, input logic [7:0] b);
        for (int i = 0; i < 8; i++) sensor_bits[idx * 8 + i] = b[7 - i];
    endtask

    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        bit got;
        got = 0;
        @(posedge FSM_CLK); #1;
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge FSM_CLK);
            if (cmd_ready) begin got = 1; break; end
        end
        @(posedge FSM_CLK); #1;
        cmd_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready never rose within 400 cycles");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge FSM_CLK);
            if (!busy && cmd_ready) return;
        end
        checks++; errors++;
        $display("FAIL wait_idle: busy=%b cmd_ready=%b after 3000 cycles", busy, cmd_ready);
    endtask

    task automatic test_reset();
        RST = 1'b1; power_on = 1'b0;
        repeat (3) @(posedge FSM_CLK);
        @(negedge FSM_CLK);
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
        checks++;
        if ({CLK_IN, SYS_RES_N, SPI_EN, SPI_CLK, SPI_IN, rdata_valid, wdata_ack, cmd_ready, busy, powered} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {CLK_IN, SYS_RES_N, SPI_EN, SPI_CLK, SPI_IN, rdata_valid, wdata_ack, cmd_ready, busy, powered});
        end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        @(posedge FSM_CLK); #1; RST = 1'b0;
        repeat (5) @(negedge FSM_CLK);
        checks++;
        if (State !== 4'd0 || CLK_IN !== 1'b0) begin
            errors++; $display("FAIL off_hold: State=%0d CLK_IN=%b expected 0/0", State, CLK_IN);
        end
    endtask

    task automatic test_powerup();
        int t0, t1, t2;
        logic c0;
        t0 = -1; t1 = -1; t2 = -1;
        @(posedge FSM_CLK); #1; power_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge FSM_CLK);
            if (t0 < 0 && CLK_IN) t0 = cyc;
            if (t1 < 0 && SYS_RES_N) t1 = cyc;
            if (cmd_ready) begin t2 = cyc; break; end
        end
        checks++;
        if (t0 < 0 || t1 - t0 != 50) begin errors++; $display("FAIL warm_cycles: got %0d expected 50", t1 - t0); end
        checks++;
        if (t2 < 0 || t2 - t1 != 50) begin errors++; $display("FAIL rstwait_cycles: got %0d expected 50", t2 - t1); end
        checks++;
        if (State !== 4'd3 || powered !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_flags: State=%0d powered=%b busy=%b expected 3/1/0", State, powered, busy);
        end
        c0 = CLK_IN;
        @(negedge FSM_CLK);
        checks++;
        if (CLK_IN !== ~c0) begin errors++; $display("FAIL clk_in_toggle: got %b expected %b", CLK_IN, ~c0); end
    endtask

    task automatic test_single_write();
        wwords[0] = 8'hC3; wwords[1] = 8'h00; wdata = 8'hC3; ack_cnt = 0;
        push_bits(32'h1, 1); push_bits(32'h2A, ADDR_W); push_bits(32'hC3, DATA_W);
        send_cmd(1'b1, 7'h2A, 4'd0);
        wait_idle();
        checks++;
        if (last_edges != 16) begin errors++; $display("FAIL write_edges: got %0d expected 16", last_edges); end
        checks++;
        if (ack_cnt != 1) begin errors++; $display("FAIL write_acks: got %0d expected 1", ack_cnt); end
        checks++;
        if (exp_bits.size() != 0 || SPI_EN !== 1'b0) begin
            errors++; $display("FAIL write_end: left=%0d SPI_EN=%b expected 0/0", exp_bits.size(), SPI_EN);
        end
    endtask

    task automatic test_read_burst();
        int r0;
        set_sensor_byte(0, 8'hA5); set_sensor_byte(1, 8'h5A); set_sensor_byte(2, 8'hFF);
        exp_rdata.push_back(8'hA5); exp_rdata.push_back(8'h5A); exp_rdata.push_back(8'hFF);
        push_bits(32'h0, 1); push_bits(32'h10, ADDR_W); push_bits(32'h0, 24);
        r0 = rdv_cnt;
        send_cmd(1'b0, 7'h10, 4'd2);
        wait_idle();
        checks++;
        if (last_edges != 32) begin errors++; $display("FAIL read_edges: got %0d expected 32", last_edges); end
        checks++;
        if (rdv_cnt - r0 != 3 || exp_rdata.size() != 0) begin
            errors++; $display("FAIL read_words: got %0d pulses, %0d unmatched, expected 3/0", rdv_cnt - r0, exp_rdata.size());
        end
    endtask

    task automatic test_len_wrap();
        int r0;
        logic [7:0] b;
        for (int w = 0; w < 16; w++) begin
            b = 8'($urandom_range(1, 255));
            set_sensor_byte(w, b);
            exp_rdata.push_back(b);
        end
        push_bits(32'h0, 1); push_bits(32'h55, ADDR_W);
        for (int w = 0; w < 16; w++) push_bits(32'h0, DATA_W);
        r0 = rdv_cnt;
        send_cmd(1'b0, 7'h55, 4'hF);
        wait_idle();
        checks++;
        if (last_edges != 136) begin errors++; $display("FAIL wrap_edges: got %0d expected 136", last_edges); end
        checks++;
        if (rdv_cnt - r0 != 16) begin errors++; $display("FAIL wrap_words: got %0d expected 16", rdv_cnt - r0); end
    endtask

    task automatic test_divider();
        int rises, run, viol;
        bit seen, done;
        logic pclk, pin;
        rises = 0; run = 0; viol = 0; seen = 0; done = 0;
        @(posedge FSM_CLK); #1;
        cmd_wr = 1'b1; cmd_addr = 7'h2A; cmd_len = 4'd0; wdata = 8'hC3; cmd_valid2 = 1'b1;
        for (int i = 0; i < 100 && !cmd_ready2; i++) @(negedge FSM_CLK);
        @(posedge FSM_CLK); #1; cmd_valid2 = 1'b0;
        pclk = SPI_CLK2; pin = SPI_IN2;
        for (int i = 0; i < 400; i++) begin
            @(negedge FSM_CLK);
            if (SPI_CLK2 !== pclk) begin
                if (rises > 0) begin
                    checks++;
                    if (run != 3) begin errors++; $display("FAIL div_phase: run of %0d cycles expected 3 (edge %0d)", run, rises); end
                end
                if (SPI_CLK2) rises++;
                run = 1;
            end else run++;
            if (SPI_IN2 !== pin && SPI_CLK2) viol++;
            pclk = SPI_CLK2; pin = SPI_IN2;
            if (busy2) seen = 1;
            if (seen && !busy2) begin done = 1; break; end
        end
        checks++;
        if (!done || rises != 16) begin errors++; $display("FAIL div_edges: got %0d (done=%b) expected 16", rises, done); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL div_mosi_high: %0d changes while SPI_CLK high, expected 0", viol); end
    endtask

    task automatic test_abort();
        bit got;
        got = 0;
        wwords[0] = 8'h11; wwords[1] = 8'h22; wwords[2] = 8'h33; wwords[3] = 8'h44;
        wdata = 8'h11; ack_cnt = 0; chk_bits = 0;
        send_cmd(1'b1, 7'h05, 4'd3);
        for (int i = 0; i < 200 && ack_cnt < 2; i++) @(negedge FSM_CLK);
        repeat (3) @(posedge FSM_CLK);
        #1; power_on = 1'b0;
        @(posedge FSM_CLK);
        @(negedge FSM_CLK);
        checks++;
        if ({SPI_EN, SPI_CLK, SPI_IN, SYS_RES_N, CLK_IN} !== 5'b0) begin
            errors++; $display("FAIL abort_pins: got %b expected 00000", {SPI_EN, SPI_CLK, SPI_IN, SYS_RES_N, CLK_IN});
        end
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", State); end
        repeat (20) @(negedge FSM_CLK);
        checks++;
        if (ack_cnt != 2) begin errors++; $display("FAIL abort_acks: got %0d expected 2", ack_cnt); end
        exp_bits.delete();
        @(posedge FSM_CLK); #1; power_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge FSM_CLK);
            if (cmd_ready) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL repower: cmd_ready=%b expected 1", cmd_ready); end
        chk_bits = 1;
    endtask

    task automatic test_rst_midread();
        int a0, r0;
        bit got;
        got = 0;
        chk_bits = 0; chk_rd = 0;
        for (int w = 0; w < 2; w++) set_sensor_byte(w, 8'h3C);
        a0 = acc_cnt;
        @(posedge FSM_CLK); #1;
        cmd_wr = 1'b0; cmd_addr = 7'h33; cmd_len = 4'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 300 && edge_cnt < HDR + 4; i++) @(negedge FSM_CLK);
        checks++;
        if (acc_cnt - a0 != 1) begin errors++; $display("FAIL busy_accept: got %0d accepts expected 1", acc_cnt - a0); end
        r0 = rdv_cnt;
        #1; RST = 1'b1;
        @(posedge FSM_CLK);
        @(negedge FSM_CLK);
        checks++;
        if ({CLK_IN, SYS_RES_N, SPI_EN, SPI_CLK, SPI_IN, rdata_valid, cmd_ready, busy, powered} !== 9'b0 || State !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: got %b state %0d expected 000000000 state 0",
                     {CLK_IN, SYS_RES_N, SPI_EN, SPI_CLK, SPI_IN, rdata_valid, cmd_ready, busy, powered}, State);
        end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
        @(posedge FSM_CLK); #1; RST = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge FSM_CLK);
            if (acc_cnt - a0 == 2) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc < 100) begin errors++; $display("FAIL held_cmd_idle: accepts=%0d expected 2", acc_cnt - a0); end
        checks++;
        if (rdv_cnt != r0) begin errors++; $display("FAIL rst_partial: got %0d pulses expected 0", rdv_cnt - r0); end
        @(posedge FSM_CLK); #1; cmd_valid = 1'b0;
        @(negedge FSM_CLK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL held_cmd_busy: got %b expected 1", busy); end
        wait_idle();
        chk_bits = 1; chk_rd = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sensor_bits[i] = 1'b0;
        for (int i = 0; i < 16; i++) wwords[i] = '0;
        test_reset();
        test_powerup();
        test_single_write();
        test_read_burst();
        test_len_wrap();
        test_divider();
        test_abort();
        test_rst_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
